// File: rtl/al422_frame_writer.sv
// Write-side front end for the AL422 frame FIFO: resets the write pointer at each SOF, then writes FRAME_BYTES bytes.
// Optional build macro AL422_FRAME_WRITER_DROP_EN: discard non-SOF bytes in IDLE instead of back-pressuring them.
module al422_frame_writer #(
  parameter int FRAME_BYTES = 6144,
  parameter int WRST_CYCLES = 4
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [7:0] s_data,
  input  logic       s_sof,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] al422_data,
  output logic       al422_we_n,
  output logic       al422_wrst_n,
  output logic       frame_done,
  output logic       err
);

  localparam int CW = $clog2(FRAME_BYTES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_BYTES - 1);
  localparam logic [3:0]    WRST_LAST  = 4'(WRST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRST,
    WRITE,
    DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [3:0]    wrst_cnt_reg, wrst_cnt_next;
  logic          ready;
  logic          write_en;
  logic          abort;
  logic          frame_end;

  assign s_ready = ready;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      wrst_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      wrst_cnt_reg <= wrst_cnt_next;
    end
  end

  // s_ready depends only on state, count and s_sof, never on s_valid.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    wrst_cnt_next = wrst_cnt_reg;
    ready         = 1'b0;
    write_en      = 1'b0;
    abort         = 1'b0;
    frame_end     = 1'b0;
    case (state_reg)
      IDLE: begin
`ifdef AL422_FRAME_WRITER_DROP_EN
        ready = !s_sof;
`else
        ready = 1'b0;
`endif
        // The SOF byte is left with the source and taken as byte 0 after WRST.
        if (s_valid && s_sof) begin
          state_next    = WRST;
          wrst_cnt_next = '0;
          count_next    = '0;
        end
      end
      WRST: begin
        if (wrst_cnt_reg == WRST_LAST) begin
          state_next = WRITE;
          count_next = '0;
        end else begin
          wrst_cnt_next = wrst_cnt_reg + 4'd1;
        end
      end
      WRITE: begin
        ready = !(s_sof && (count_reg != '0));
        if (s_valid && ready) begin
          write_en = 1'b1;
          if (count_reg == LAST_COUNT) begin
            state_next = DONE;
            frame_end  = 1'b1;
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end else if (s_valid && s_sof) begin
          // Short frame: restart the write pointer; the held SOF byte becomes byte 0.
          abort         = 1'b1;
          state_next    = WRST;
          wrst_cnt_next = '0;
          count_next    = '0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // WRST and accepted writes are mutually exclusive by state, so WE_n and WRST_n never overlap.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      al422_data   <= '0;
      al422_we_n   <= 1'b1;
      al422_wrst_n <= 1'b1;
      frame_done   <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (write_en) begin
        al422_data <= s_data;
      end
      al422_we_n   <= !write_en;
      al422_wrst_n <= (state_next != WRST);
      frame_done   <= frame_end;
      err          <= abort;
    end
  end

endmodule

// File: tb/tb_al422_frame_writer.sv
// Directed bench for al422_frame_writer: a 6-byte-frame instance for protocol corners and a
// default-size instance for a full frame with random source gaps, both checked against byte queues.
module tb_al422_frame_writer;

  logic       clk = 1'b0;
  logic       in_rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_sof = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] al_data;
  logic       we_n, wrst_n, frame_done, err;

  logic [7:0] b_data = 8'h00;
  logic       b_sof = 1'b0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [7:0] b_al_data;
  logic       b_we_n, b_wrst_n, b_done, b_err;

  always #5 clk = ~clk;

  al422_frame_writer #(.FRAME_BYTES(6), .WRST_CYCLES(4)) u_dut (
    .in_clk(clk), .in_rst(in_rst), .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready), .al422_data(al_data), .al422_we_n(we_n), .al422_wrst_n(wrst_n),
    .frame_done(frame_done), .err(err)
  );

  al422_frame_writer u_big (
    .in_clk(clk), .in_rst(in_rst), .s_data(b_data), .s_sof(b_sof), .s_valid(b_valid),
    .s_ready(b_ready), .al422_data(b_al_data), .al422_we_n(b_we_n), .al422_wrst_n(b_wrst_n),
    .frame_done(b_done), .err(b_err)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  logic [7:0] bq[$];

  int   ncyc = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int   wrst_run = 0, last_wrst_low = 0, last_wr = -100, last_gap = 0;
  bit   lat_pend = 1'b0;
  logic prev_wrst_n = 1'b1;
  int   b_wr = 0, b_done_cnt = 0;
  bit   b_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Small-instance monitor: scoreboard pop on every write plus timing relations.
  always @(negedge clk) begin
    ncyc++;
    check("we_wrst_exclusive", 32'(we_n === 1'b0 && wrst_n === 1'b0), 0);
    if (wrst_n === 1'b0) begin
      wrst_run++;
      last_wrst_low = ncyc;
      lat_pend = 1'b1;
    end else if (wrst_run != 0) begin
      check("wrst_len", wrst_run, 4);
      wrst_run = 0;
    end
    if (we_n === 1'b0) begin
      wr_cnt++;
      if (q.size() == 0) check("write_without_expect", 32'(q.size()), 1);
      else check("write_data", 32'(al_data), 32'(q.pop_front()));
      if (lat_pend) begin
        check("wrst_to_first_write", ncyc - last_wrst_low, 2);
        lat_pend = 1'b0;
      end
      if (ncyc - last_wr > 1) last_gap = ncyc - last_wr;
      last_wr = ncyc;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      check("done_with_last_we", 32'(we_n), 0);
    end
    if (err === 1'b1) begin
      err_cnt++;
      check("err_in_first_wrst", {30'd0, wrst_n, prev_wrst_n}, 32'b01);
    end
    prev_wrst_n = wrst_n;
  end

  // Big-instance monitor: every write must follow a transfer one edge earlier.
  always @(negedge clk) begin
    check("big_we_follows_xfer", 32'(b_we_n === 1'b0), 32'(b_pend));
    if (b_we_n === 1'b0) begin
      b_wr++;
      if (bq.size() == 0) check("big_write_without_expect", 32'(bq.size()), 1);
      else check("big_write_data", 32'(b_al_data), 32'(bq.pop_front()));
    end
    if (b_done === 1'b1) b_done_cnt++;
    b_pend = b_valid && b_ready;
  end

  task automatic send(input logic [7:0] d, input logic sof, input logic wr);
    bit got = 1'b0;
    s_data = d;
    s_sof = sof;
    s_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (s_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("accept_timeout", 32'(got), 1);
      s_valid = 1'b0;
      s_sof = 1'b0;
      return;
    end
    @(posedge clk);
    if (wr) q.push_back(d);
    #1;
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic frame6(input logic [7:0] base);
    for (int i = 0; i < 6; i++) send(8'(base + 8'(i)), i == 0, 1'b1);
  endtask

  task automatic send_big(input int idx);
    bit got = 1'b0;
    while ($urandom_range(0, 1) == 1) begin
      b_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    b_data = 8'(idx * 7) ^ 8'h5A;
    b_sof = (idx == 0);
    b_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (b_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("big_accept_timeout", 32'(got), 1);
      b_valid = 1'b0;
      return;
    end
    @(posedge clk);
    bq.push_back(b_data);
    #1;
    b_valid = 1'b0;
    b_sof = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, e0, w0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    in_rst = 1'b0;
    @(negedge clk);
    check("rst_data", 32'(al_data), 0);
    check("rst_we_n", 32'(we_n), 1);
    check("rst_wrst_n", 32'(wrst_n), 1);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_err", 32'(err), 0);
`ifdef AL422_FRAME_WRITER_DROP_EN
    check("rst_ready", 32'(s_ready), 1);
`else
    check("rst_ready", 32'(s_ready), 0);
`endif
    @(posedge clk);
    #1;

    // Single frame, valid held high
    frame6(8'h10);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_cnt", done_cnt, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_writes", wr_cnt, 6);
    check("t1_queue_empty", 32'(q.size()), 0);

    // Abort: SOF at count 3
    d0 = done_cnt;
    send(8'h20, 1'b1, 1'b1);
    send(8'h21, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    send(8'hA5, 1'b1, 1'b1);
    check("t3_no_done_on_abort", done_cnt, d0);
    check("t3_err_cnt", err_cnt, 1);
    for (int i = 1; i < 6; i++) send(8'(8'hA5 + 8'(i)), 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t3_done_cnt", done_cnt, d0 + 1);
    check("t3_queue_empty", 32'(q.size()), 0);

    // Reset mid-WRITE at count 2
    d0 = done_cnt;
    send(8'h40, 1'b1, 1'b1);
    send(8'h41, 1'b0, 1'b1);
    in_rst = 1'b1;
    @(posedge clk);
    #1;
    in_rst = 1'b0;
    @(negedge clk);
    check("t4_rst_data", 32'(al_data), 0);
    check("t4_rst_we_n", 32'(we_n), 1);
    check("t4_rst_wrst_n", 32'(wrst_n), 1);
    check("t4_rst_done", 32'(frame_done), 0);
    check("t4_rst_err", 32'(err), 0);
    @(posedge clk);
    #1;
    frame6(8'h50);
    repeat (3) @(posedge clk);
    #1;
    check("t4_done_cnt", done_cnt, d0 + 1);
    check("t4_queue_empty", 32'(q.size()), 0);

    // Non-SOF bytes in IDLE, then SOF 0x33
    d0 = done_cnt;
    w0 = wr_cnt;
`ifdef AL422_FRAME_WRITER_DROP_EN
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
`else
    s_data = 8'h01;
    s_sof = 1'b0;
    s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_ready_low_01", 32'(s_ready), 0);
    end
    s_data = 8'h02;
    repeat (3) begin
      @(negedge clk);
      check("t5_ready_low_02", 32'(s_ready), 0);
    end
    @(posedge clk);
    #1;
`endif
    check("t5_no_idle_writes", wr_cnt, w0);
    send(8'h33, 1'b1, 1'b1);
    for (int i = 1; i < 6; i++) send(8'(8'h33 + 8'(i)), 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_done_cnt", done_cnt, d0 + 1);
    check("t5_writes", wr_cnt, w0 + 6);

    // Back-to-back frames
    d0 = done_cnt;
    e0 = err_cnt;
    frame6(8'h60);
    frame6(8'h70);
    repeat (3) @(posedge clk);
    #1;
    check("t6_gap", last_gap, 7);
    check("t6_done_cnt", done_cnt, d0 + 2);
    check("t6_err_cnt", err_cnt, e0);
    check("t6_queue_empty", 32'(q.size()), 0);

    // Full default-size frame with random source gaps
    for (int i = 0; i < 6144; i++) send_big(i);
    repeat (4) @(posedge clk);
    #1;
    check("big_writes", b_wr, 6144);
    check("big_queue_empty", 32'(bq.size()), 0);
    check("big_done_cnt", b_done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/al422_frame_writer.md
# al422_frame_writer

Write-side front end for the AL422 frame buffer: accepts a byte stream with start-of-frame marking over a valid/ready handshake, issues an AL422 write-pointer reset at each frame start, then writes exactly FRAME_BYTES bytes into the FIFO. It sits directly upstream of al422_bam, which reads the same FIFO and drives the HUB75 panel. It guarantees that every frame starts at FIFO address 0, so the reader's address reset stays aligned with pixel 0.

## Interface
- FRAME_BYTES, 6144, bytes per frame (64x32 pixels, 3 bytes each); legal range 2..65535
- WRST_CYCLES, 4, cycles al422_wrst_n is held low per frame start; legal range 1..15
- in_clk  input  1  system clock; also drives AL422 WCK
- in_rst  input  1  reset; one clock, synchronous, active-high
- s_data  input  8  stream byte
- s_sof  input  1  qualifies s_data as byte 0 of a frame
- s_valid  input  1  source has a byte
- s_ready  output  1  block accepts; transfer = s_valid & s_ready at the in_clk rising edge
- al422_data  output  8  AL422 DI bus, registered
- al422_we_n  output  1  AL422 write enable, active-low, registered
- al422_wrst_n  output  1  AL422 write-pointer reset, active-low, registered
- frame_done  output  1  one-cycle pulse after the last byte of a frame is written
- err  output  1  one-cycle pulse on a short (aborted) frame

## Operation
- State machine: IDLE, WRST, WRITE, DONE.
- IDLE:
  - s_valid & s_sof -> WRST. The SOF byte is not consumed here.
  - Non-SOF bytes are handled according to Configuration.
- WRST:
  - al422_wrst_n = 0 for exactly WRST_CYCLES cycles; s_ready = 0.
  - Then -> WRITE with byte count = 0.
- WRITE:
  - s_ready = !(s_sof & count != 0).
  - Each transfer: al422_data <= s_data, al422_we_n <= 0 for one cycle, count++.
  - When the transfer with count == FRAME_BYTES-1 completes -> DONE.
  - A SOF byte arriving with count != 0 is not accepted: err pulses and the block goes to WRST (abort). The source holds that byte, and it is accepted as byte 0 after the write-pointer reset.
  - The byte at count 0 is accepted whether or not its s_sof is set.
- DONE:
  - frame_done = 1 for one cycle, s_ready = 0, then -> IDLE.
- Count is $clog2(FRAME_BYTES) bits wide. It never exceeds FRAME_BYTES-1 and does not wrap.
- The block never asserts al422_we_n = 0 and al422_wrst_n = 0 in the same cycle.
- Reset (in_rst = 1, any state, including mid-frame):
  - State -> IDLE, count = 0, al422_data = 0, al422_we_n = 1, al422_wrst_n = 1, frame_done = 0, err = 0.
  - A partially written frame is abandoned. The next SOF re-issues WRST.

## Timing
- s_ready is combinational from state, count and s_sof. No combinational path from s_valid to s_ready.
- Accepted byte to al422_we_n low: 1 cycle latency. Data and WE_n change on the same edge and are stable for one full WCK period.
- SOF seen in IDLE to first al422_we_n low: 1 (entry to WRST) + WRST_CYCLES + 1 (accept) cycles. With defaults: WRST during cycles 1..4, byte 0 accepted at edge 5, al422_we_n low in cycle 6.
- Sustained throughput in WRITE: 1 byte/cycle.
- Last-byte transfer to frame_done: frame_done is high during the cycle after the edge that enters DONE, concurrently with the final al422_we_n low.
- Minimum gap between frames: DONE cycle + IDLE cycle + WRST.
- err is asserted in the first WRST cycle of the abort.

## Configuration
- AL422_FRAME_WRITER_DROP_EN defined:
  - In IDLE, s_ready = !s_sof, and non-SOF bytes are accepted and discarded (no write).
  - The writer resynchronises to a free-running source.
- Not defined:
  - In IDLE, s_ready = 0; non-SOF bytes are back-pressured until an SOF byte is presented.
  - This prevents a stalled source from losing data.
- WRITE, WRST and DONE behave identically in both builds.

## Test plan
- Single frame, FRAME_BYTES=6 (test override), WRST_CYCLES=4, bytes 0x10..0x15, s_valid held high:
  - al422_wrst_n low exactly 4 cycles.
  - Then 6 consecutive al422_we_n low cycles carrying 0x10..0x15.
  - frame_done pulses once; err stays 0.
- Random s_valid gaps (≈50% duty) over a full 6144-byte frame:
  - Write count is exactly 6144 and data order is preserved.
  - al422_we_n is never low without a preceding transfer.
- Abort: SOF presented at count 3 of a 6-byte frame:
  - err pulses and 4 WRST cycles follow.
  - The SOF byte (0xA5) is the next written byte. No frame_done for the aborted frame.
- Reset asserted for one cycle mid-WRITE (count 2):
  - All outputs return to their reset values on the next edge.
  - A following SOF produces a full WRST plus 6 writes.
- Non-SOF bytes 0x01, 0x02 in IDLE, then SOF 0x33:
  - With AL422_FRAME_WRITER_DROP_EN: both are accepted without any write, and 0x33 is the first write.
  - Without it: s_ready stays 0 until the source presents 0x33 with s_sof set.
- Back-to-back frames, s_valid always high:
  - al422_wrst_n and al422_we_n are never low together.
  - The gap between the last write of frame N and the first write of frame N+1 is as specified in Timing.
